// File: rtl/sys_top.sv
// rtl/sys_top.sv - UART command system: serial RX, command FSM, register file, ALU, serial TX
// Frames are start, LSB-first data, even parity, stop; all logic on REF_CLK rising edge.
module sys_top #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 16,
  parameter int RF_DEPTH   = 16
) (
  input  logic REF_CLK,
  input  logic RST,
  input  logic RX_IN,
  output logic TX_OUT,
  output logic PAR_ERR,
  output logic STP_ERR
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int FW = DATA_WIDTH + 3;
  localparam int BW = $clog2(FW);
  localparam int AW = $clog2(RF_DEPTH);
  localparam int RW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] HALF     = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] STOP_BIT = BW'(FW - 1);
  localparam logic [BW-1:0] PAR_BIT  = BW'(FW - 2);
  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FN  = DATA_WIDTH'(8'hDD);

  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic [2:0] {
    C_IDLE, C_WR_ADDR, C_WR_DATA, C_RD_ADDR, C_OP_A, C_OP_B, C_FUNC, C_RESP
  } cmd_state_t;

  rx_state_t r_rx_state, w_rx_next;
  logic r_rx_s1, r_rx_s2, r_rx_s3;
  logic [CW-1:0] r_rx_cnt;
  logic [BW-1:0] r_rx_bit;
  logic [DATA_WIDTH-1:0] r_rx_shift, r_rx_byte;
  logic r_rx_par, r_rx_valid, r_par_err, r_stp_err;
  logic w_rx_fall, w_rx_sample, w_rx_par_bad, w_rx_err;

  assign w_rx_fall    = !r_rx_s2 && r_rx_s3;
  assign w_rx_sample  = (r_rx_state == RX_BUSY) && (r_rx_cnt == HALF);
  assign w_rx_par_bad = (^r_rx_shift) != r_rx_par;
  assign w_rx_err     = r_par_err || r_stp_err;
  assign PAR_ERR      = r_par_err;
  assign STP_ERR      = r_stp_err;

  always_ff @(posedge REF_CLK) begin
    if (RST) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE: if (w_rx_fall) w_rx_next = RX_BUSY;
      default: if (w_rx_sample && ((r_rx_bit == '0 && r_rx_s2) || r_rx_bit == STOP_BIT))
                 w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
      r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_shift <= '0; r_rx_byte <= '0;
      r_rx_par <= 1'b0; r_rx_valid <= 1'b0; r_par_err <= 1'b0; r_stp_err <= 1'b0;
    end else begin
      r_rx_s1 <= RX_IN; r_rx_s2 <= r_rx_s1; r_rx_s3 <= r_rx_s2;
      r_rx_valid <= 1'b0; r_par_err <= 1'b0; r_stp_err <= 1'b0;
      if (r_rx_state == RX_IDLE) begin
        r_rx_cnt <= '0;
        r_rx_bit <= '0;
      end else begin
        r_rx_cnt <= (r_rx_cnt == LAST) ? '0 : r_rx_cnt + 1'b1;
        if (r_rx_cnt == LAST) r_rx_bit <= r_rx_bit + 1'b1;
        if (w_rx_sample) begin
          if (r_rx_bit == STOP_BIT) begin
            r_par_err  <= w_rx_par_bad;
            r_stp_err  <= !r_rx_s2;
            r_rx_valid <= !w_rx_par_bad && r_rx_s2;
            r_rx_byte  <= r_rx_shift;
          end else if (r_rx_bit == PAR_BIT) begin
            r_rx_par <= r_rx_s2;
          end else if (r_rx_bit != '0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_WIDTH-1:1]};
          end
        end
      end
    end
  end

  cmd_state_t r_cmd_state, w_cmd_next;
  logic [DATA_WIDTH-1:0] r_rf [RF_DEPTH];
  logic [AW-1:0] r_addr;
  logic r_tx_req, r_tx_two;
  logic [DATA_WIDTH-1:0] r_tx_b0, r_tx_b1, w_a, w_b;
  logic [RW-1:0] w_alu;
  logic w_tx_done;
  tx_state_t r_tx_state, w_tx_next;

  assign w_a = r_rf[0];
  assign w_b = r_rf[1];
  assign w_tx_done = (r_tx_state == TX_IDLE) && !r_tx_req;

  always_ff @(posedge REF_CLK) begin
    if (RST) r_cmd_state <= C_IDLE;
    else     r_cmd_state <= w_cmd_next;
  end

  // A bad frame aborts any partial command, but never an in-flight response.
  always_comb begin
    w_cmd_next = r_cmd_state;
    case (r_cmd_state)
      C_RESP: if (w_tx_done) w_cmd_next = C_IDLE;
      default: begin
        if (w_rx_err) begin
          w_cmd_next = C_IDLE;
        end else if (r_rx_valid) begin
          case (r_cmd_state)
            C_IDLE: begin
              if (r_rx_byte == CMD_WR)       w_cmd_next = C_WR_ADDR;
              else if (r_rx_byte == CMD_RD)  w_cmd_next = C_RD_ADDR;
              else if (r_rx_byte == CMD_ALU) w_cmd_next = C_OP_A;
              else if (r_rx_byte == CMD_FN)  w_cmd_next = C_FUNC;
            end
            C_WR_ADDR: w_cmd_next = C_WR_DATA;
            C_WR_DATA: w_cmd_next = C_IDLE;
            C_OP_A:    w_cmd_next = C_OP_B;
            C_OP_B:    w_cmd_next = C_FUNC;
            default:   w_cmd_next = C_RESP;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (r_rx_byte[3:0])
      4'h0: w_alu = RW'(w_a) + RW'(w_b);
      4'h1: w_alu = RW'(w_a) - RW'(w_b);
      4'h2: w_alu = RW'(w_a) * RW'(w_b);
      4'h3: w_alu = (w_b == '0) ? '0 : {{DATA_WIDTH{1'b0}}, w_a / w_b};
      4'h4: w_alu = {{DATA_WIDTH{1'b0}}, w_a & w_b};
      4'h5: w_alu = {{DATA_WIDTH{1'b0}}, w_a | w_b};
      4'h6: w_alu = {{DATA_WIDTH{1'b0}}, ~(w_a & w_b)};
      4'h7: w_alu = {{DATA_WIDTH{1'b0}}, ~(w_a | w_b)};
      4'h8: w_alu = {{DATA_WIDTH{1'b0}}, w_a ^ w_b};
      4'h9: w_alu = {{DATA_WIDTH{1'b0}}, ~(w_a ^ w_b)};
      4'hA: w_alu = {{(RW-1){1'b0}}, w_a == w_b};
      4'hB: w_alu = {{(RW-1){1'b0}}, w_a > w_b};
      4'hC: w_alu = {{(RW-1){1'b0}}, w_a < w_b};
      4'hD: w_alu = {{DATA_WIDTH{1'b0}}, w_a >> 1};
      4'hE: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_a, 1'b0};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
      r_addr <= '0; r_tx_req <= 1'b0; r_tx_two <= 1'b0; r_tx_b0 <= '0; r_tx_b1 <= '0;
    end else begin
      if (r_tx_state == TX_IDLE) r_tx_req <= 1'b0;
      if (r_rx_valid) begin
        case (r_cmd_state)
          C_WR_ADDR: r_addr <= r_rx_byte[AW-1:0];
          C_WR_DATA: r_rf[r_addr] <= r_rx_byte;
          C_OP_A:    r_rf[0] <= r_rx_byte;
          C_OP_B:    r_rf[1] <= r_rx_byte;
          C_RD_ADDR: begin
            r_tx_b0  <= r_rf[r_rx_byte[AW-1:0]];
            r_tx_two <= 1'b0;
            r_tx_req <= 1'b1;
          end
          C_FUNC: begin
            r_tx_b0  <= w_alu[DATA_WIDTH-1:0];
            r_tx_b1  <= w_alu[RW-1:DATA_WIDTH];
            r_tx_two <= 1'b1;
            r_tx_req <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic [FW-1:0] r_tx_frame;
  logic [CW-1:0] r_tx_cnt;
  logic [BW-1:0] r_tx_bit;
  logic r_tx_more, r_tx_out;

  assign TX_OUT = r_tx_out;

  always_ff @(posedge REF_CLK) begin
    if (RST) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (r_tx_req) w_tx_next = TX_BUSY;
      default: if (r_tx_cnt == LAST && r_tx_bit == STOP_BIT && !r_tx_more) w_tx_next = TX_IDLE;
    endcase
  end

  // r_tx_frame holds the bits still to send after the current one, padded with idle 1s.
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      r_tx_frame <= '1; r_tx_cnt <= '0; r_tx_bit <= '0; r_tx_more <= 1'b0; r_tx_out <= 1'b1;
    end else if (r_tx_state == TX_IDLE) begin
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      if (r_tx_req) begin
        r_tx_out   <= 1'b0;
        r_tx_frame <= {2'b11, ^r_tx_b0, r_tx_b0};
        r_tx_more  <= r_tx_two;
      end
    end else if (r_tx_cnt != LAST) begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end else begin
      r_tx_cnt <= '0;
      if (r_tx_bit != STOP_BIT) begin
        r_tx_bit   <= r_tx_bit + 1'b1;
        r_tx_out   <= r_tx_frame[0];
        r_tx_frame <= {1'b1, r_tx_frame[FW-1:1]};
      end else if (r_tx_more) begin
        r_tx_bit   <= '0;
        r_tx_out   <= 1'b0;
        r_tx_frame <= {2'b11, ^r_tx_b1, r_tx_b1};
        r_tx_more  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sys_top.sv
// tb/tb_sys_top.sv - directed vector bench for the UART command system
module tb_sys_top;
  localparam int BC = 16;

  logic REF_CLK = 1'b0;
  logic RST = 1'b1;
  logic RX_IN = 1'b1;
  logic TX_OUT, PAR_ERR, STP_ERR;

  sys_top #(.DATA_WIDTH(8), .BIT_CYCLES(BC), .RF_DEPTH(16)) dut (
    .REF_CLK(REF_CLK), .RST(RST), .RX_IN(RX_IN),
    .TX_OUT(TX_OUT), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 REF_CLK = ~REF_CLK;

  typedef struct {
    logic [31:0] cmd;
    int          ncmd;
    int          nresp;
    logic [15:0] resp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int par_cnt = 0;
  int stp_cnt = 0;
  int tx_bad = 0;
  int tx_start_cyc = 0;
  int last_start = 0;
  logic [7:0] tx_q[$];
  vec_t vecs[17];

  always @(posedge REF_CLK) cyc <= cyc + 1;

  always @(negedge REF_CLK) begin
    if (PAR_ERR === 1'b1) par_cnt++;
    if (STP_ERR === 1'b1) stp_cnt++;
  end

  initial begin : tx_capture
    logic [7:0] d;
    logic p, s;
    forever begin
      @(negedge REF_CLK);
      if (!RST && TX_OUT === 1'b0) begin
        tx_start_cyc = cyc;
        repeat (BC/2) @(negedge REF_CLK);
        if (TX_OUT !== 1'b0) tx_bad++;
        for (int i = 0; i < 8; i++) begin
          repeat (BC) @(negedge REF_CLK);
          d[i] = TX_OUT;
        end
        repeat (BC) @(negedge REF_CLK);
        p = TX_OUT;
        repeat (BC) @(negedge REF_CLK);
        s = TX_OUT;
        if (p !== ^d || s !== 1'b1) tx_bad++;
        tx_q.push_back(d);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge REF_CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    last_start = cyc;
    for (int i = 0; i < 11; i++) begin
      RX_IN = f[i];
      wait_cyc(BC);
    end
    RX_IN = 1'b1;
    wait_cyc(4);
  endtask

  task automatic clear_obs();
    tx_q.delete();
    par_cnt = 0;
    stp_cnt = 0;
    tx_bad = 0;
  endtask

  task automatic run_cmd(input string name, input logic [31:0] cmd, input int ncmd,
                         input int nresp, input logic [15:0] resp);
    logic [7:0] b;
    clear_obs();
    for (int j = 0; j < ncmd; j++) begin
      b = cmd[31-8*j -: 8];
      send_byte(b, 1'b0, 1'b0);
    end
    wait_cyc(nresp * 180 + 40);
    chk({name, "_len"}, tx_q.size(), nresp);
    for (int k = 0; k < nresp; k++) begin
      b = resp[8*k +: 8];
      if (tx_q.size() > k) chk($sformatf("%s_b%0d", name, k), tx_q[k], b);
    end
    chk({name, "_rxerr"}, par_cnt + stp_cnt, 0);
    chk({name, "_frame"}, tx_bad, 0);
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0]  = '{32'hAA057E00, 3, 0, 16'h0000};
    vecs[1]  = '{32'hBB050000, 2, 1, 16'h007E};
    vecs[2]  = '{32'hBB030000, 2, 1, 16'h0000};
    vecs[3]  = '{32'h55000000, 1, 0, 16'h0000};
    vecs[4]  = '{32'hCCFF0F01, 4, 2, 16'h00F0};
    vecs[5]  = '{32'hDD020000, 2, 2, 16'h0EF1};
    vecs[6]  = '{32'hDD030000, 2, 2, 16'h0011};
    vecs[7]  = '{32'hDD0B0000, 2, 2, 16'h0001};
    vecs[8]  = '{32'hDD0C0000, 2, 2, 16'h0000};
    vecs[9]  = '{32'hDD0E0000, 2, 2, 16'h01FE};
    vecs[10] = '{32'hDD0D0000, 2, 2, 16'h007F};
    vecs[11] = '{32'hDD080000, 2, 2, 16'h00F0};
    vecs[12] = '{32'hCC030501, 4, 2, 16'hFFFE};
    vecs[13] = '{32'hCC5A0F06, 4, 2, 16'h00F5};
    vecs[14] = '{32'hCC070003, 4, 2, 16'h0000};
    vecs[15] = '{32'hBB010000, 2, 1, 16'h0000};
    vecs[16] = '{32'hBB000000, 2, 1, 16'h0007};

    wait_cyc(4);
    @(negedge REF_CLK);
    chk("rst_tx", TX_OUT, 1'b1);
    chk("rst_par", PAR_ERR, 1'b0);
    chk("rst_stp", STP_ERR, 1'b0);
    @(posedge REF_CLK);
    #1 RST = 1'b0;
    wait_cyc(4);

    for (int i = 0; i < 17; i++)
      run_cmd($sformatf("v%0d", i), vecs[i].cmd, vecs[i].ncmd, vecs[i].nresp, vecs[i].resp);

    clear_obs();
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      wait_cyc(1);
      if (tx_q.size() > 0) seen = 1;
    end
    chk("lat_seen", seen, 1'b1);
    lat = tx_start_cyc - last_start;
    chk("lat_window", (lat >= 172 && lat <= 174), 1'b1);
    if (seen) chk("lat_data", tx_q[0], 8'h7E);
    wait_cyc(40);

    clear_obs();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    wait_cyc(40);
    chk("perr_par", par_cnt, 1);
    chk("perr_stp", stp_cnt, 0);
    chk("perr_noresp", tx_q.size(), 0);
    run_cmd("perr_rd5", 32'hBB050000, 2, 1, 16'h007E);

    clear_obs();
    send_byte(8'hBB, 1'b0, 1'b1);
    send_byte(8'h05, 1'b0, 1'b0);
    wait_cyc(220);
    chk("serr_stp", stp_cnt, 1);
    chk("serr_par", par_cnt, 0);
    chk("serr_noresp", tx_q.size(), 0);

    clear_obs();
    RX_IN = 1'b0;
    wait_cyc(3);
    RX_IN = 1'b1;
    wait_cyc(60);
    chk("glitch_err", par_cnt + stp_cnt, 0);
    chk("glitch_noresp", tx_q.size(), 0);
    run_cmd("glitch_rd5", 32'hBB050000, 2, 1, 16'h007E);

    clear_obs();
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    seen = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      wait_cyc(1);
      if (TX_OUT === 1'b0) seen = 1;
    end
    chk("rstmid_txstart", seen, 1'b1);
    wait_cyc(40);
    RST = 1'b1;
    @(posedge REF_CLK);
    @(negedge REF_CLK);
    chk("rstmid_tx_high", TX_OUT, 1'b1);
    @(posedge REF_CLK);
    #1 RST = 1'b0;
    wait_cyc(400);
    run_cmd("rstmid_rd5", 32'hBB050000, 2, 1, 16'h0000);
    run_cmd("rstmid_rd0", 32'hBB000000, 2, 1, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
